lotr_run_ctrl: RTL and testbench

//  Run/reset/single-step sequencer between the board buttons/switches and the lotr core cluster.
//  - Debounces Button_0 (core reset request) and Button_1 (step request).
//  - Generates a timed core reset and a core clock-enable.
//  - Lets the board free-run the cores or advance them STEP_CYCLES QClk cycles per button press.
//  - Sits in the QClk (50 kHz) domain; status outputs drive LEDs.

---
 rtl/lotr_run_ctrl.sv | 159 +++++++++++++++
 tb/tb_lotr_run_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lotr_run_ctrl.sv
// lotr_run_ctrl: run/reset/single-step sequencer between the board buttons
// and switches and the lotr core cluster. Runs entirely in the QClk domain.
//   QClk          core clock, rising edge
//   RstQnnnH      asynchronous active-high reset
//   Button0N      raw active-low button: core reset request
//   Button1N      raw active-low button: step request
//   SwStepMode    raw switch: 1 = step mode, 0 = free-run
//   CoreRstQnnnH  registered reset to the core cluster
//   CoreEnQnnnH   registered clock-enable to the core cluster
//   CtrlState     0 RST_HOLD, 1 RUN, 2 STEP_IDLE, 3 STEP_BURST
//   StepCount     step bursts started since reset, wraps 255->0
module lotr_run_ctrl #(
  parameter int unsigned DEB_CYCLES  = 500,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned CNT_W       = 10
) (
  input  logic       QClk,
  input  logic       RstQnnnH,
  input  logic       Button0N,
  input  logic       Button1N,
  input  logic       SwStepMode,
  output logic       CoreRstQnnnH,
  output logic       CoreEnQnnnH,
  output logic [1:0] CtrlState,
  output logic [7:0] StepCount
);

  typedef enum logic [1:0] {
    ST_RST_HOLD   = 2'd0,
    ST_RUN        = 2'd1,
    ST_STEP_IDLE  = 2'd2,
    ST_STEP_BURST = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(STEP_CYCLES - 1);

  // bit 0 = Button0N, bit 1 = Button1N, bit 2 = SwStepMode
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;

  logic [1:0]            deb_q, deb_d;
  logic [1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]            press_q, press_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic             core_rst_q, core_rst_d;
  logic             core_en_q, core_en_d;

  logic mode;
  assign mode = sync2_q[2];

  always_comb begin
    sync1_d = {SwStepMode, Button1N, Button0N};
    sync2_d = sync1_q;
  end

  // A level is accepted after DEB_CYCLES consecutive mismatching cycles;
  // any cycle of agreement restarts the count.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    press_d   = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
      press_d[i] = deb_q[i] & ~deb_d[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    burst_cnt_d = burst_cnt_q;
    step_cnt_d  = step_cnt_q;
    if (press_q[0]) begin
      state_d    = ST_RST_HOLD;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_RST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            state_d    = mode ? ST_STEP_IDLE : ST_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (mode) state_d = ST_STEP_IDLE;
        end
        ST_STEP_IDLE: begin
          if (press_q[1]) begin
            state_d     = ST_STEP_BURST;
            burst_cnt_d = '0;
            step_cnt_d  = step_cnt_q + 1'b1;
          end else if (!mode) begin
            state_d = ST_RUN;
          end
        end
        ST_STEP_BURST: begin
          if (burst_cnt_q == BURST_LAST) begin
            burst_cnt_d = '0;
            state_d     = ST_STEP_IDLE;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_RST_HOLD;
      endcase
    end
    // Outputs are decoded from the next state so they switch on the entry edge.
    core_rst_d = (state_d == ST_RST_HOLD);
    core_en_d  = (state_d == ST_RUN) || (state_d == ST_STEP_BURST);
  end

  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      deb_q       <= '1;
      deb_cnt_q   <= '0;
      press_q     <= '0;
      state_q     <= ST_RST_HOLD;
      hold_cnt_q  <= '0;
      burst_cnt_q <= '0;
      step_cnt_q  <= '0;
      core_rst_q  <= 1'b1;
      core_en_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      press_q     <= press_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      step_cnt_q  <= step_cnt_d;
      core_rst_q  <= core_rst_d;
      core_en_q   <= core_en_d;
    end
  end

  assign CoreRstQnnnH = core_rst_q;
  assign CoreEnQnnnH  = core_en_q;
  assign CtrlState    = state_q;
  assign StepCount    = step_cnt_q;

endmodule

// File: tb/tb_lotr_run_ctrl.sv
// Bench for lotr_run_ctrl. Instance 0 uses default parameters (DEB 500,
// STEP 1); instance 1 uses DEB 4, STEP 5 so long step sequences stay short.
module tb_lotr_run_ctrl;

  localparam int DEB_A = 500;
  localparam int DEB_B = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      b0n, b1n, mode;
  logic [1:0]      core_rst, core_en;
  logic [1:0][1:0] st;
  logic [1:0][7:0] cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lotr_run_ctrl u_dut_a (
    .QClk        (clk),
    .RstQnnnH    (rst),
    .Button0N    (b0n[0]),
    .Button1N    (b1n[0]),
    .SwStepMode  (mode[0]),
    .CoreRstQnnnH(core_rst[0]),
    .CoreEnQnnnH (core_en[0]),
    .CtrlState   (st[0]),
    .StepCount   (cnt[0])
  );

  lotr_run_ctrl #(
    .DEB_CYCLES (DEB_B),
    .RST_HOLD   (16),
    .STEP_CYCLES(5),
    .CNT_W      (10)
  ) u_dut_b (
    .QClk        (clk),
    .RstQnnnH    (rst),
    .Button0N    (b0n[1]),
    .Button1N    (b1n[1]),
    .SwStepMode  (mode[1]),
    .CoreRstQnnnH(core_rst[1]),
    .CoreEnQnnnH (core_en[1]),
    .CtrlState   (st[1]),
    .StepCount   (cnt[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for core_en of instance u to rise; returns cycles waited.
  task automatic wait_en(input int u, output int n);
    n = 0;
    while (!core_en[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Counts consecutive samples with core_en high for instance u.
  task automatic count_en(input int u, output int m);
    m = 0;
    while (core_en[u] && m < 100) begin
      m++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, m, bad, entries, rsthigh, pulses;
    logic [1:0] prev;

    rst  = 1'b1;
    b0n  = 2'b11;
    b1n  = 2'b11;
    mode = 2'b10;
    cycles(3);
    check_eq("rst_core_rst_a", core_rst[0], 1);
    check_eq("rst_core_en_a",  core_en[0],  0);
    check_eq("rst_state_a",    st[0],       0);
    check_eq("rst_count_a",    cnt[0],      0);
    check_eq("rst_state_b",    st[1],       0);

    // T1: hold lasts 16 samples counted from the release point
    rst = 1'b0;
    n = 0;
    while (core_rst[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("t1_hold_len", n, 16);
    check_eq("t1_state_a",  st[0], 1);
    check_eq("t1_en_a",     core_en[0], 1);
    check_eq("t1_state_b",  st[1], 2);
    check_eq("t1_en_b",     core_en[1], 0);
    check_eq("t1_rst_b",    core_rst[1], 0);

    // T2: bounce shorter than the debounce window, then hold low
    bad = 0;
    for (int t = 0; t < 8; t++) begin
      b0n[0] = (t % 2 == 0) ? 1'b0 : 1'b1;
      repeat (50) begin
        @(negedge clk);
        if (st[0] == 2'd0) bad++;
      end
    end
    check_eq("t2_no_rst_bounce", bad, 0);
    b0n[0] = 1'b0;
    n = 0;
    while (st[0] != 2'd0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    // raw edge before E0, sync E0/E1, count E2..E(D), accept E(D+1), state E(D+2)
    check_eq("t2_press_latency", n, DEB_A + 3);
    check_eq("t2_core_rst", core_rst[0], 1);
    entries = 1;
    rsthigh = 1;
    prev = st[0];
    repeat (600) begin
      @(negedge clk);
      if (st[0] == 2'd0 && prev != 2'd0) entries++;
      if (core_rst[0]) rsthigh++;
      prev = st[0];
    end
    check_eq("t2_one_entry", entries, 1);
    check_eq("t2_hold_len",  rsthigh, 16);
    b0n[0] = 1'b1;
    cycles(DEB_A + 10);
    check_eq("t2_back_run", st[0], 1);

    // T3: step mode, three clean presses of one cycle each
    mode[0] = 1'b1;
    cycles(5);
    check_eq("t3_step_idle", st[0], 2);
    for (int k = 0; k < 3; k++) begin
      pulses = 0;
      b1n[0] = 1'b0;
      repeat (DEB_A + 10) begin
        @(negedge clk);
        if (core_en[0]) pulses++;
      end
      b1n[0] = 1'b1;
      repeat (DEB_A + 10) begin
        @(negedge clk);
        if (core_en[0]) pulses++;
      end
      check_eq("t3_pulse_len", pulses, 1);
    end
    check_eq("t3_count", cnt[0], 3);
    check_eq("t3_state", st[0],  2);

    // T4: 5-cycle burst, mode dropped during the burst
    b1n[1] = 1'b0;
    wait_en(1, n);
    check_eq("t4_burst_latency", n, DEB_B + 3);
    mode[1] = 1'b0;
    count_en(1, m);
    check_eq("t4_burst_len",   m, 5);
    check_eq("t4_after_burst", st[1], 2);
    @(negedge clk);
    check_eq("t4_then_run", st[1], 1);
    check_eq("t4_count",    cnt[1], 1);
    b1n[1]  = 1'b1;
    mode[1] = 1'b1;
    cycles(20);
    check_eq("t4_back_idle", st[1], 2);

    // T5a: both presses in the same cycle
    b0n[1] = 1'b0;
    b1n[1] = 1'b0;
    n = 0;
    while (st[1] == 2'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5a_latency", n, DEB_B + 3);
    check_eq("t5a_state",   st[1], 0);
    check_eq("t5a_en",      core_en[1], 0);
    check_eq("t5a_count",   cnt[1], 1);
    b0n[1] = 1'b1;
    b1n[1] = 1'b1;
    cycles(40);
    check_eq("t5a_recover", st[1], 2);

    // T5b: Press0 lands in the third burst cycle
    b1n[1] = 1'b0;
    cycles(3);
    b0n[1] = 1'b0;
    wait_en(1, n);
    count_en(1, m);
    check_eq("t5b_burst_cut", m, 3);
    check_eq("t5b_state",     st[1], 0);
    check_eq("t5b_rst",       core_rst[1], 1);
    check_eq("t5b_count",     cnt[1], 2);
    b0n[1] = 1'b1;
    b1n[1] = 1'b1;
    cycles(40);
    check_eq("t5b_recover", st[1], 2);

    // T6: StepCount wrap
    for (int k = 0; k < 254; k++) begin
      b1n[1] = 1'b0;
      cycles(8);
      b1n[1] = 1'b1;
      cycles(12);
      if (k == 252) check_eq("t6_count_255", cnt[1], 255);
    end
    check_eq("t6_wrap",  cnt[1], 0);
    check_eq("t6_state", st[1],  2);

    // T6b: asynchronous reset in the middle of a burst
    b1n[1] = 1'b0;
    wait_en(1, n);
    cycles(2);
    check_eq("t6b_in_burst", st[1], 3);
    #2 rst = 1'b1;
    #1;
    check_eq("t6b_core_rst", core_rst[1], 1);
    check_eq("t6b_core_en",  core_en[1],  0);
    check_eq("t6b_state",    st[1],       0);
    check_eq("t6b_count",    cnt[1],      0);
    check_eq("t6b_count_a",  cnt[0],      0);
    @(negedge clk);
    b1n[1] = 1'b1;
    rst = 1'b0;
    cycles(30);
    check_eq("t6b_recover", st[1], 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
